// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multicycle controller and the MIPS datapath
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrc;
  logic       EXTop;
  logic [2:0] ALUop;
  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, MemtoReg, ALUSrc, EXTop, ALUop
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, MemtoReg, ALUSrc, EXTop, ALUop
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle MIPS datapath with a shared memory port
module multicycle_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    bus,
  output logic [2:0]           state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t state_q, state_d;
  logic is_r, is_addu, is_subu, is_sll, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal, known;
  logic [4:0] alu_ctl;
  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  always_comb begin
    is_r    = bus.op == 6'b000000;
    is_addu = is_r && bus.funct == 6'b100001;
    is_subu = is_r && bus.funct == 6'b100011;
    is_sll  = is_r && bus.funct == 6'b000000;
    is_jr   = is_r && bus.funct == 6'b001000;
    is_ori  = bus.op == 6'b001101;
    is_lw   = bus.op == 6'b100011;
    is_sw   = bus.op == 6'b101011;
    is_beq  = bus.op == 6'b000100;
    is_lui  = bus.op == 6'b001111;
    is_j    = bus.op == 6'b000010;
    is_jal  = bus.op == 6'b000011;
    known   = is_addu | is_subu | is_sll | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_j | is_jal;
    // {ALUop, ALUSrc, EXTop}
    alu_ctl = is_addu ? 5'b010_0_0 :
              (is_subu | is_beq) ? 5'b110_0_0 :
              is_sll ? 5'b011_0_0 :
              is_ori ? 5'b001_1_1 :
              is_lui ? 5'b111_1_0 :
              (is_lw | is_sw) ? 5'b010_1_0 : 5'b000_0_0;
  end
  always_comb begin
    state_d    = FETCH;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
        state_d  = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        pc_write   = is_j | is_jal | is_jr;
        pc_src     = is_jr ? 2'b11 : (is_j | is_jal) ? 2'b10 : 2'b00;
        reg_write  = is_jal;
        reg_dst    = is_jal ? 2'b10 : 2'b00;
        mem_to_reg = is_jal ? 2'b10 : 2'b00;
        state_d    = (is_j | is_jal | is_jr | !known) ? FETCH : EXEC;
      end
      EXEC: begin
        pc_write = is_beq & bus.zero;
        pc_src   = is_beq ? 2'b01 : 2'b00;
        state_d  = is_beq ? FETCH : (is_lw | is_sw) ? MEM : WB;
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_sw;
        state_d = !bus.mem_ready ? MEM : is_lw ? WB : FETCH;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (is_addu | is_subu | is_sll) ? 2'b01 : 2'b00;
        mem_to_reg = is_lw ? 2'b01 : 2'b00;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    state_q <= reset ? FETCH : state_d;
  logic alu_live;
  assign alu_live     = !reset && (state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB);
  assign state        = state_q;
  assign bus.mem_req  = !reset & mem_req;
  assign bus.mem_we   = !reset & mem_we;
  assign bus.IorD     = !reset & iord;
  assign bus.IRWrite  = !reset & ir_write;
  assign bus.PCWrite  = !reset & pc_write;
  assign bus.PCSrc    = reset ? 2'b00 : pc_src;
  assign bus.RegWrite = !reset & reg_write;
  assign bus.RegDst   = reset ? 2'b00 : reg_dst;
  assign bus.MemtoReg = reset ? 2'b00 : mem_to_reg;
  assign bus.ALUop    = alu_live ? alu_ctl[4:2] : 3'b000;
  assign bus.ALUSrc   = alu_live & alu_ctl[1];
  assign bus.EXTop    = alu_live & alu_ctl[0];
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences with hand-computed per-cycle state and strobe vectors
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] state;
  int n_cmp = 0;
  int n_err = 0;
  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master), .state(state));
  always #5 clk = ~clk;
  function automatic logic [16:0] v(input logic mr, we, iord, irw, pcw, input logic [1:0] pcs,
                                    input logic rw, input logic [1:0] rd, m2r, input logic as, ext,
                                    input logic [2:0] aop);
    return {mr, we, iord, irw, pcw, pcs, rw, rd, m2r, as, ext, aop};
  endfunction
  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic ck(input string tag, input logic [2:0] s, input logic [16:0] c);
    @(negedge clk);
    chk(tag, {state, bus.mem_req, bus.mem_we, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.RegWrite,
              bus.RegDst, bus.MemtoReg, bus.ALUSrc, bus.EXTop, bus.ALUop}, {s, c});
    @(posedge clk);
    #1;
  endtask
  localparam logic [16:0] F_GO   = 17'b1_0_0_1_1_00_0_00_00_0_0_000;
  localparam logic [16:0] F_WAIT = 17'b1_0_0_0_0_00_0_00_00_0_0_000;
  initial begin
    reset = 1'b1; bus.op = 6'd0; bus.funct = 6'b100001; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #1;
    ck("rst0", 3'd0, 17'd0);
    ck("rst1", 3'd0, 17'd0);
    reset = 1'b0;
    ck("addu.F", 3'd0, F_GO);
    ck("addu.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b010));
    ck("addu.E", 3'd2, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b010));
    ck("addu.W", 3'd4, v(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,0,3'b010));
    bus.op = 6'b100011; bus.mem_ready = 1'b0;
    ck("lw.Fw0", 3'd0, F_WAIT);
    ck("lw.Fw1", 3'd0, F_WAIT);
    bus.mem_ready = 1'b1;
    ck("lw.F", 3'd0, F_GO);
    ck("lw.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    ck("lw.E", 3'd2, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) ck("lw.Mw", 3'd3, v(1,0,1,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    bus.mem_ready = 1'b1;
    ck("lw.M", 3'd3, v(1,0,1,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    ck("lw.W", 3'd4, v(0,0,0,0,0,2'b00,1,2'b00,2'b01,1,0,3'b010));
    bus.op = 6'b000100; bus.zero = 1'b1;
    ck("beq1.F", 3'd0, F_GO);
    ck("beq1.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b110));
    ck("beq1.E", 3'd2, v(0,0,0,0,1,2'b01,0,2'b00,2'b00,0,0,3'b110));
    bus.zero = 1'b0;
    ck("beq0.F", 3'd0, F_GO);
    ck("beq0.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b110));
    ck("beq0.E", 3'd2, v(0,0,0,0,0,2'b01,0,2'b00,2'b00,0,0,3'b110));
    bus.op = 6'b000011;
    ck("jal.F", 3'd0, F_GO);
    ck("jal.D", 3'd1, v(0,0,0,0,1,2'b10,1,2'b10,2'b10,0,0,3'b000));
    bus.op = 6'b000000; bus.funct = 6'b001000;
    ck("jr.F", 3'd0, F_GO);
    ck("jr.D", 3'd1, v(0,0,0,0,1,2'b11,0,2'b00,2'b00,0,0,3'b000));
    bus.op = 6'b000010;
    ck("j.F", 3'd0, F_GO);
    ck("j.D", 3'd1, v(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,0,3'b000));
    bus.op = 6'b001101;
    ck("ori.F", 3'd0, F_GO);
    ck("ori.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,3'b001));
    ck("ori.E", 3'd2, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,3'b001));
    ck("ori.W", 3'd4, v(0,0,0,0,0,2'b00,1,2'b00,2'b00,1,1,3'b001));
    bus.op = 6'b000000; bus.funct = 6'b000000;
    ck("sll.F", 3'd0, F_GO);
    ck("sll.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b011));
    ck("sll.E", 3'd2, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b011));
    ck("sll.W", 3'd4, v(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,0,3'b011));
    bus.op = 6'b001111;
    ck("lui.F", 3'd0, F_GO);
    ck("lui.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b111));
    ck("lui.E", 3'd2, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b111));
    ck("lui.W", 3'd4, v(0,0,0,0,0,2'b00,1,2'b00,2'b00,1,0,3'b111));
    bus.op = 6'b101011;
    ck("sw.F", 3'd0, F_GO);
    ck("sw.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    ck("sw.E", 3'd2, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    ck("sw.M", 3'd3, v(1,1,1,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    bus.op = 6'b111111;
    ck("ill.F", 3'd0, F_GO);
    ck("ill.D", 3'd1, 17'd0);
    bus.op = 6'b000000; bus.funct = 6'b111111;
    ck("illr.F", 3'd0, F_GO);
    ck("illr.D", 3'd1, 17'd0);
    bus.op = 6'b101011;
    ck("swr.F", 3'd0, F_GO);
    ck("swr.D", 3'd1, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    ck("swr.E", 3'd2, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b010));
    reset = 1'b1;
    ck("swr.Mrst", 3'd3, 17'd0);
    reset = 1'b0;
    ck("post.F", 3'd0, F_GO);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
